// File: rtl/window_gen_kxk_pkg.sv
// window_pkg: shared types and helpers for the KxK sliding-window generator.
//   fsm_state_t : control FSM encoding (IDLE / RUN / ERR)
//   CNT_W       : width of row/column counters and frame-size fields
//   ADDR_W      : line-buffer address width for the default MAX_WIDTH
//   win_idx     : flat element index of window element (i,j) for side k
package window_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERR
  } fsm_state_t;

  localparam int unsigned CNT_W         = 8;
  localparam int unsigned MAX_WIDTH_DEF = 128;
  localparam int unsigned ADDR_W        = $clog2(MAX_WIDTH_DEF);

  function automatic int unsigned win_idx(input int unsigned i,
                                          input int unsigned j,
                                          input int unsigned k = 3);
    return i * k + j;
  endfunction

endpackage

// File: rtl/window_gen_kxk_line_buffer.sv
// line_buffer: one image row of pixel storage, 1R1W, addressed by column.
// The read is combinational from the current contents, so on a write cycle
// rd_data_o returns the pixel stored one line earlier at the same column.
//   clk       : clock
//   wr_en_i   : write (accepted pixel)
//   addr_i    : column address
//   wr_data_i : pixel to store
//   rd_data_o : pixel previously stored at addr_i
module line_buffer
  import window_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_WIDTH = 128
) (
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [$clog2(MAX_WIDTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  output logic [DATA_W-1:0]            rd_data_o
);

  logic [DATA_W-1:0] mem_q [MAX_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen_kxk.sv
// window_gen_kxk: streaming KxK sliding-window generator.
// Takes one raster-order pixel per accepted in_valid and, once the window is
// fully inside the image, presents the KxK neighbourhood with its output-map
// row/column. Frame size and stride are latched on start.
//   clk, rst_n              : clock, async active-low reset
//   start                   : latch config and begin a frame (aborts any frame)
//   stage_width/height      : frame size, sampled on start
//   stride2                 : 1 = stride 2, sampled on start
//   in_valid, pix_in        : pixel input
//   win_valid, win_data     : window output, element (i,j) at win_idx(i,j)*DATA_W
//   win_row, win_col        : output-map coordinates of the window
//   frame_done              : pulse with the result of the last pixel of a frame
//   cfg_err                 : illegal config seen; cleared by the next legal start
//   busy                    : frame in progress
module window_gen_kxk
  import window_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned K          = 3,
  parameter int unsigned MAX_WIDTH  = 128,
  parameter int unsigned MAX_HEIGHT = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            stage_width,
  input  logic [7:0]            stage_height,
  input  logic                  stride2,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     pix_in,
  output logic                  win_valid,
  output logic [K*K*DATA_W-1:0] win_data,
  output logic [7:0]            win_row,
  output logic [7:0]            win_col,
  output logic                  frame_done,
  output logic                  cfg_err,
  output logic                  busy
);

  localparam int unsigned      AW     = $clog2(MAX_WIDTH);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] K_C    = CNT_W'(K);
  localparam logic [CNT_W-1:0] KM1    = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] MAXW_C = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] MAXH_C = CNT_W'(MAX_HEIGHT);

  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] w_q, h_q, c_q, r_q, c_d, r_d;
  logic             s2_q;
  logic [CNT_W-1:0] cur_w, cur_h, cur_c, cur_r, rr, cc;
  logic             cur_s2, legal, accept, last_pix, qual;
  logic             win_valid_q, frame_done_q;
  logic [7:0]       win_row_q, win_col_q;

  logic [DATA_W-1:0] win_q  [K][K];
  logic [DATA_W-1:0] col_in [K];
  logic [DATA_W-1:0] lb_in  [K-1];
  logic [DATA_W-1:0] lb_out [K-1];

  // A start cycle works under the new config with counters at (0,0), so a
  // pixel arriving alongside start is treated as the first of the new frame.
  assign cur_w  = start ? stage_width  : w_q;
  assign cur_h  = start ? stage_height : h_q;
  assign cur_s2 = start ? stride2      : s2_q;
  assign cur_c  = start ? '0 : c_q;
  assign cur_r  = start ? '0 : r_q;

  assign legal = (stage_width  >= K_C) && (stage_width  <= MAXW_C) &&
                 (stage_height >= K_C) && (stage_height <= MAXH_C);
  assign last_pix = (cur_c == cur_w - ONE) && (cur_r == cur_h - ONE);

  assign rr   = cur_r - KM1;
  assign cc   = cur_c - KM1;
  assign qual = (cur_r >= KM1) && (cur_c >= KM1) && (!cur_s2 || (!rr[0] && !cc[0]));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (start)                                            state_d = legal ? RUN : ERR;
    else if (state_q == RUN && in_valid && last_pix)      state_d = IDLE;
  end

  // FSM: outputs
  always_comb begin
    accept  = in_valid && (start ? legal : (state_q == RUN));
    busy    = (state_q == RUN);
    cfg_err = (state_q == ERR);
  end

  always_comb begin
    c_d = cur_c;
    r_d = cur_r;
    if (accept) begin
      if (cur_c == cur_w - ONE) begin
        c_d = '0;
        r_d = last_pix ? '0 : cur_r + ONE;
      end else begin
        c_d = cur_c + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q  <= '0;
      r_q  <= '0;
      w_q  <= '0;
      h_q  <= '0;
      s2_q <= 1'b0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
      if (start && legal) begin
        w_q  <= stage_width;
        h_q  <= stage_height;
        s2_q <= stride2;
      end
    end
  end

  // Row buffers are chained: buffer n holds the stream delayed by n+1 lines.
  always_comb begin
    for (int unsigned n = 0; n < K - 1; n++) lb_in[n] = pix_in;
    for (int unsigned n = 1; n < K - 1; n++) lb_in[n] = lb_out[n-1];
  end

  for (genvar n = 0; n < K - 1; n++) begin : g_lb
    line_buffer #(
      .DATA_W    (DATA_W),
      .MAX_WIDTH (MAX_WIDTH)
    ) u_lb (
      .clk       (clk),
      .wr_en_i   (accept),
      .addr_i    (cur_c[AW-1:0]),
      .wr_data_i (lb_in[n]),
      .rd_data_o (lb_out[n])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < K; i++) col_in[i] = pix_in;
    for (int unsigned i = 0; i < K - 1; i++) col_in[i] = lb_out[K-2-i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < K; i++)
        for (int unsigned j = 0; j < K; j++) win_q[i][j] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j < K - 1; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][K-1] <= col_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      win_valid_q  <= accept && qual;
      frame_done_q <= accept && last_pix;
      if (accept && qual) begin
        win_row_q <= cur_s2 ? (rr >> 1) : rr;
        win_col_q <= cur_s2 ? (cc >> 1) : cc;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < K; i++)
      for (int unsigned j = 0; j < K; j++)
        win_data[win_idx(i, j, K)*DATA_W +: DATA_W] = win_q[i][j];
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_window_gen_kxk.sv
// Directed bench for window_gen_kxk with K=3, DATA_W=8.
module tb_window_gen_kxk;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  stage_width = '0;
  logic [7:0]  stage_height = '0;
  logic        stride2 = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        win_valid;
  logic [71:0] win_data;
  logic [7:0]  win_row, win_col;
  logic        frame_done, cfg_err, busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int nwin, ndone;
  logic [71:0] first_win, second_win;

  always #5 clk = ~clk;

  window_gen_kxk #(
    .DATA_W     (8),
    .K          (3),
    .MAX_WIDTH  (128),
    .MAX_HEIGHT (128)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stage_width  (stage_width),
    .stage_height (stage_height),
    .stride2      (stride2),
    .in_valid     (in_valid),
    .pix_in       (pix_in),
    .win_valid    (win_valid),
    .win_data     (win_data),
    .win_row      (win_row),
    .win_col      (win_col),
    .frame_done   (frame_done),
    .cfg_err      (cfg_err),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Element (i,j) of the window ending at pixel (r,c) is pixel (r-2+i, c-2+j).
  function automatic logic [71:0] model_win(input int r, input int c, input int base);
    logic [71:0] d;
    d = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        d[(i*3+j)*8 +: 8] = 8'(base + (r - 2 + i) * 16 + (c - 2 + j));
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input logic s2, input bit gaps,
                           input bit start_pix, input int base, input int npix,
                           input int exp_nwin, input string name);
    int  n;
    bit  ev, last;
    n = 0;
    nwin = 0;
    ndone = 0;
    stage_width  = 8'(w);
    stage_height = 8'(h);
    stride2      = s2;
    start        = 1'b1;
    if (!start_pix) begin
      tick();
      check({name, "/start_cfg_err"}, cfg_err, 0);
      check({name, "/start_busy"}, busy, 1);
      check({name, "/start_win_valid"}, win_valid, 0);
    end
    for (int r = 0; r < h && n < npix; r++) begin
      for (int c = 0; c < w && n < npix; c++) begin
        if (gaps) begin
          for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
            in_valid = 1'b0;
            tick();
            check({name, "/stall_win_valid"}, win_valid, 0);
            check({name, "/stall_frame_done"}, frame_done, 0);
          end
        end
        in_valid = 1'b1;
        pix_in   = 8'(base + r * 16 + c);
        tick();
        ev   = (r >= 2) && (c >= 2) && (!s2 || ((r % 2 == 0) && (c % 2 == 0)));
        last = (r == h - 1) && (c == w - 1);
        check({name, "/win_valid"}, win_valid, ev);
        check({name, "/frame_done"}, frame_done, last);
        check({name, "/busy"}, busy, !last);
        check({name, "/cfg_err"}, cfg_err, 0);
        if (ev) begin
          check({name, "/win_row"}, win_row, s2 ? (r - 2) / 2 : r - 2);
          check({name, "/win_col"}, win_col, s2 ? (c - 2) / 2 : c - 2);
          check({name, "/win_data"}, win_data, model_win(r, c, base));
          if (nwin == 0) first_win = win_data;
          else if (nwin == 1) second_win = win_data;
          nwin++;
        end
        if (frame_done) ndone++;
        n++;
      end
    end
    check({name, "/n_windows"}, nwin, exp_nwin);
    check({name, "/n_frame_done"}, ndone, (npix >= w * h) ? 1 : 0);
  endtask

  initial begin
    logic [7:0] b;

    // Reset state
    #12;
    check("rst/win_valid", win_valid, 0);
    check("rst/win_data", win_data, 0);
    check("rst/win_row", win_row, 0);
    check("rst/win_col", win_col, 0);
    check("rst/frame_done", frame_done, 0);
    check("rst/cfg_err", cfg_err, 0);
    check("rst/busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: 5x5 stride 1, back-to-back
    run_frame(5, 5, 1'b0, 1'b0, 1'b0, 0, 25, 9, "T1");
    b = first_win[7:0];
    check("T1/first_e00", b, 8'h00);
    b = first_win[71:64];
    check("T1/first_e22", b, 8'h22);

    // T2: same frame with random stalls
    run_frame(5, 5, 1'b0, 1'b1, 1'b0, 0, 25, 9, "T2");

    // T3: 7x7 stride 2, first pixel arrives with start
    run_frame(7, 7, 1'b1, 1'b0, 1'b1, 0, 49, 9, "T3");
    b = first_win[71:64];
    check("T3/first_e22", b, 8'h22);
    b = second_win[71:64];
    check("T3/second_e22", b, 8'h24);

    // 6x6 stride 2: last pixel yields no window but still ends the frame
    run_frame(6, 6, 1'b1, 1'b0, 1'b0, 0, 36, 4, "T3even");

    // Non-square frame
    run_frame(8, 3, 1'b0, 1'b0, 1'b0, 0, 24, 6, "WxH");

    // T4: illegal width, pixels ignored, legal start clears the error
    stage_width  = 8'd2;
    stage_height = 8'd5;
    start        = 1'b1;
    tick();
    check("T4/cfg_err_set", cfg_err, 1);
    check("T4/busy_err", busy, 0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      pix_in   = 8'(k);
      tick();
      check("T4/ignored_win_valid", win_valid, 0);
      check("T4/ignored_frame_done", frame_done, 0);
      check("T4/ignored_busy", busy, 0);
    end
    run_frame(4, 4, 1'b0, 1'b0, 1'b0, 0, 16, 4, "T4legal");

    // Illegal start during a frame (height above limit) aborts into ERR
    run_frame(5, 5, 1'b0, 1'b0, 1'b0, 0, 7, 0, "T4run");
    stage_height = 8'd200;
    start        = 1'b1;
    in_valid     = 1'b1;
    tick();
    check("T4run/cfg_err", cfg_err, 1);
    check("T4run/busy", busy, 0);
    check("T4run/win_valid", win_valid, 0);
    check("T4run/frame_done", frame_done, 0);

    // T5: abort a 6x6 frame after 12 pixels, then a full 4x4 frame
    run_frame(6, 6, 1'b0, 1'b0, 1'b0, 8'h80, 12, 0, "T5abort");
    run_frame(4, 4, 1'b0, 1'b0, 1'b1, 0, 16, 4, "T5new");

    // T6: asynchronous reset mid-frame while a window is being presented
    run_frame(5, 5, 1'b0, 1'b0, 1'b0, 0, 13, 1, "T6pre");
    #2;
    rst_n = 1'b0;
    #1;
    check("T6/win_valid", win_valid, 0);
    check("T6/win_data", win_data, 0);
    check("T6/win_row", win_row, 0);
    check("T6/win_col", win_col, 0);
    check("T6/frame_done", frame_done, 0);
    check("T6/cfg_err", cfg_err, 0);
    check("T6/busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      pix_in   = 8'(8'h50 + k);
      tick();
      check("T6/idle_win_valid", win_valid, 0);
      check("T6/idle_busy", busy, 0);
    end
    run_frame(5, 5, 1'b0, 1'b0, 1'b0, 0, 25, 9, "T6post");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
